shift_arbiter: RTL and testbench



---
 rtl/shift_arbiter.sv | 191 +++++++++++++++++++
 tb/tb_shift_arbiter.sv | 359 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/shift_arbiter.sv
// shift_arbiter: two ports share one barrel shifter via round-robin issue.
// Optional SHIFT_ARB_STALLCNT_EN adds per-port stall counters.

module shifter (
  input  logic [2:0]  mode_i,
  input  logic [4:0]  amt_i,
  input  logic [31:0] data_i,
  output logic [31:0] data_o
);
  // Mode-selected shift; modes other than SRL/SRA shift left
  always_comb begin
    data_o = data_i << amt_i;
    unique case (mode_i)
      3'b010:  data_o = data_i >> amt_i;
      3'b011:  data_o = 32'($signed(data_i) >>> amt_i);
      default: data_o = data_i << amt_i;
    endcase
  end
endmodule

module shift_arbiter #(
  parameter int DW   = 32,
  parameter int TAGW = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [1:0]        req_valid,
  output logic [1:0]        req_ready,
  input  logic [5:0]        req_mode,
  input  logic [1:0]        req_src,
  input  logic [9:0]        req_shamt,
  input  logic [2*DW-1:0]   req_rshamt,
  input  logic [2*DW-1:0]   req_data,
  input  logic [2*TAGW-1:0] req_tag,
  output logic [1:0]        resp_valid,
  input  logic [1:0]        resp_ready,
  output logic [2*DW-1:0]   resp_data,
  output logic [2*TAGW-1:0] resp_tag
`ifdef SHIFT_ARB_STALLCNT_EN
  ,
  output logic [31:0]       stall_cnt0,
  output logic [31:0]       stall_cnt1
`endif
);

  logic [1:0]      elig, gnt;
  logic            sel, src;
  logic            rr_q, rr_d;
  logic            iss_vld_q, iss_vld_d;
  logic            iss_own_q, iss_own_d;
  logic [2:0]      iss_mode_q, iss_mode_d;
  logic [4:0]      iss_amt_q, iss_amt_d;
  logic [DW-1:0]   iss_data_q, iss_data_d;
  logic [TAGW-1:0] iss_tag_q, iss_tag_d;
  logic [DW-1:0]   shf_out;
  logic [1:0]      rv_q, rv_d;
  logic [2*DW-1:0] rd_q, rd_d;
  logic [2*TAGW-1:0] rt_q, rt_d;
  logic            unused_rshamt;

  assign unused_rshamt = ^{req_rshamt[2*DW-1:DW+5],
                           req_rshamt[DW-1:5]};

  // A port is blocked while its result is still in flight or unconsumed
  always_comb begin
    elig[0] = req_valid[0] & (~rv_q[0] | resp_ready[0])
            & ~(iss_vld_q & ~iss_own_q);
    elig[1] = req_valid[1] & (~rv_q[1] | resp_ready[1])
            & ~(iss_vld_q & iss_own_q);
    if (rst)
      gnt = 2'b00;
    else if (&elig)
      gnt = rr_q ? 2'b10 : 2'b01;
    else
      gnt = elig;
    sel  = gnt[1];
    rr_d = (|gnt) ? gnt[0] : rr_q;
  end

  // Select the granted port's fields into the issue register
  always_comb begin
    src        = req_src[sel];
    iss_vld_d  = |gnt;
    iss_own_d  = iss_own_q;
    iss_mode_d = iss_mode_q;
    iss_amt_d  = iss_amt_q;
    iss_data_d = iss_data_q;
    iss_tag_d  = iss_tag_q;
    if (|gnt) begin
      iss_own_d  = sel;
      iss_mode_d = sel ? req_mode[5:3] : req_mode[2:0];
      if (src)
        iss_amt_d = sel ? req_rshamt[DW+4:DW] : req_rshamt[4:0];
      else
        iss_amt_d = sel ? req_shamt[9:5] : req_shamt[4:0];
      iss_data_d = sel ? req_data[2*DW-1:DW] : req_data[DW-1:0];
      iss_tag_d  = sel ? req_tag[2*TAGW-1:TAGW] : req_tag[TAGW-1:0];
    end
  end

  // Issue stage and round-robin pointer
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr_q       <= 1'b0;
      iss_vld_q  <= 1'b0;
      iss_own_q  <= 1'b0;
      iss_mode_q <= '0;
      iss_amt_q  <= '0;
      iss_data_q <= '0;
      iss_tag_q  <= '0;
    end else begin
      rr_q       <= rr_d;
      iss_vld_q  <= iss_vld_d;
      iss_own_q  <= iss_own_d;
      iss_mode_q <= iss_mode_d;
      iss_amt_q  <= iss_amt_d;
      iss_data_q <= iss_data_d;
      iss_tag_q  <= iss_tag_d;
    end
  end

  shifter shifter (
    .mode_i (iss_mode_q),
    .amt_i  (iss_amt_q),
    .data_i (iss_data_q),
    .data_o (shf_out)
  );

  // Result buffers: drain on handshake, refill from the issue stage
  always_comb begin
    rv_d = rv_q & ~resp_ready;
    rd_d = rd_q;
    rt_d = rt_q;
    if (iss_vld_q) begin
      if (iss_own_q) begin
        rv_d[1]               = 1'b1;
        rd_d[2*DW-1:DW]       = shf_out;
        rt_d[2*TAGW-1:TAGW]   = iss_tag_q;
      end else begin
        rv_d[0]               = 1'b1;
        rd_d[DW-1:0]          = shf_out;
        rt_d[TAGW-1:0]        = iss_tag_q;
      end
    end
  end

  // Result buffer registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rv_q <= '0;
      rd_q <= '0;
      rt_q <= '0;
    end else begin
      rv_q <= rv_d;
      rd_q <= rd_d;
      rt_q <= rt_d;
    end
  end

  assign req_ready  = gnt;
  assign resp_valid = rv_q;
  assign resp_data  = rd_q;
  assign resp_tag   = rt_q;

`ifdef SHIFT_ARB_STALLCNT_EN
  logic [31:0] sc0_q, sc0_d, sc1_q, sc1_d;

  // Saturating count of cycles a valid request is held off
  always_comb begin
    sc0_d = sc0_q;
    sc1_d = sc1_q;
    if (req_valid[0] & ~gnt[0] & ~&sc0_q) sc0_d = sc0_q + 32'd1;
    if (req_valid[1] & ~gnt[1] & ~&sc1_q) sc1_d = sc1_q + 32'd1;
  end

  // Stall counter registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sc0_q <= '0;
      sc1_q <= '0;
    end else begin
      sc0_q <= sc0_d;
      sc1_q <= sc1_d;
    end
  end

  assign stall_cnt0 = sc0_q;
  assign stall_cnt1 = sc1_q;
`endif

endmodule

// File: tb/tb_shift_arbiter.sv
// tb_shift_arbiter: directed vectors with a scoreboard queue per port.
// Monitor pops and compares each result the DUT presents.

module tb_shift_arbiter;

  typedef struct {
    logic [2:0]  mode;
    logic        src;
    logic [4:0]  shamt;
    logic [31:0] rsh;
    logic [31:0] data;
    logic [3:0]  tag;
    logic [31:0] exp;
  } vec_t;

  typedef struct {
    logic [31:0] d;
    logic [3:0]  t;
    int          at;
  } exp_t;

  logic        clk, rst;
  logic        vld0, vld1, rdy0, rdy1;
  logic [2:0]  mode0, mode1;
  logic        src0, src1;
  logic [4:0]  sh0, sh1;
  logic [31:0] rsh0, rsh1, dat0, dat1;
  logic [3:0]  tag0, tag1;
  logic [1:0]  req_valid, req_ready, resp_valid, resp_ready;
  logic [5:0]  req_mode;
  logic [1:0]  req_src;
  logic [9:0]  req_shamt;
  logic [63:0] req_rshamt, req_data, resp_data;
  logic [7:0]  req_tag, resp_tag;
`ifdef SHIFT_ARB_STALLCNT_EN
  logic [31:0] sc0, sc1;
`endif

  assign req_valid  = {vld1, vld0};
  assign resp_ready = {rdy1, rdy0};
  assign req_mode   = {mode1, mode0};
  assign req_src    = {src1, src0};
  assign req_shamt  = {sh1, sh0};
  assign req_rshamt = {rsh1, rsh0};
  assign req_data   = {dat1, dat0};
  assign req_tag    = {tag1, tag0};

  shift_arbiter #(.DW(32), .TAGW(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_mode   (req_mode),
    .req_src    (req_src),
    .req_shamt  (req_shamt),
    .req_rshamt (req_rshamt),
    .req_data   (req_data),
    .req_tag    (req_tag),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_data  (resp_data),
    .resp_tag   (resp_tag)
`ifdef SHIFT_ARB_STALLCNT_EN
    ,
    .stall_cnt0 (sc0),
    .stall_cnt1 (sc1)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int   cyc = 0;
  int   nchk = 0;
  int   nfail = 0;
  logic hold0 = 1'b0;
  logic [1:0] pv = '0, ph = '0;
  exp_t q0[$], q1[$];
  int   glog[$], gcyc[$];
  vec_t v0[4], v1[4];

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #300000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic drive(input int p, input vec_t v, input logic val);
    if (p == 0) begin
      mode0 = v.mode; src0 = v.src; sh0 = v.shamt;
      rsh0 = v.rsh; dat0 = v.data; tag0 = v.tag; vld0 = val;
    end else begin
      mode1 = v.mode; src1 = v.src; sh1 = v.shamt;
      rsh1 = v.rsh; dat1 = v.data; tag1 = v.tag; vld1 = val;
    end
  endtask

  task automatic send(input int p, input vec_t v, output int waited);
    int   n;
    exp_t e;
    n = 0;
    waited = -1;
    drive(p, v, 1'b1);
    while (n < 40) begin
      @(negedge clk);
      if (req_ready[p]) break;
      n++;
    end
    nchk++;
    if (n >= 40) begin
      nfail++;
      $display("FAIL grant_timeout port %0d: no req_ready in 40 cycles, required a grant", p);
    end else begin
      waited = n;
      e.d = v.exp; e.t = v.tag; e.at = cyc + 2;
      if (p == 0) q0.push_back(e);
      else        q1.push_back(e);
      glog.push_back(p);
      gcyc.push_back(cyc + 1);
    end
    @(posedge clk);
    #1;
    if (p == 0) vld0 = 1'b0;
    else        vld1 = 1'b0;
  endtask

  task automatic stream(input int p);
    int w;
    for (int k = 0; k < 4; k++)
      send(p, (p == 0) ? v0[k] : v1[k], w);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((q0.size() != 0 || q1.size() != 0) && n < 60) begin
      @(posedge clk);
      n++;
    end
    nchk++;
    if (n >= 60) begin
      nfail++;
      $display("FAIL drain: %0d/%0d results still pending, required 0/0", q0.size(), q1.size());
    end
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    #1;
    q0.delete(); q1.delete();
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic chk(input int i);
    exp_t        e;
    logic [31:0] d;
    logic [3:0]  t;
    if (!resp_valid[i]) return;
    d = resp_data[i*32 +: 32];
    t = resp_tag[i*4 +: 4];
    nchk++;
    if ((i == 0 && q0.size() == 0) || (i == 1 && q1.size() == 0)) begin
      nfail++;
      $display("FAIL resp%0d_unexpected: data %h tag %h, required no response", i, d, t);
      return;
    end
    e = (i == 0) ? q0[0] : q1[0];
    nchk++;
    if (d !== e.d || t !== e.t) begin
      nfail++;
      $display("FAIL resp%0d_data: got %h tag %h, required %h tag %h", i, d, t, e.d, e.t);
    end
    if (!pv[i] || ph[i]) begin
      nchk++;
      if (cyc != e.at) begin
        nfail++;
        $display("FAIL resp%0d_latency: appeared after edge %0d, required %0d", i, cyc, e.at);
      end
    end
    if (resp_ready[i]) begin
      if (i == 0) void'(q0.pop_front());
      else        void'(q1.pop_front());
    end
  endtask

  // Monitor: compare every presented result against the scoreboard
  initial forever begin
    @(negedge clk);
    if (rst) begin
      pv = '0;
      ph = '0;
    end else begin
      nchk++;
      if (req_ready == 2'b11) begin
        nfail++;
        $display("FAIL onehot: req_ready %b, required at most one bit", req_ready);
      end
      if (hold0) begin
        nchk++;
        if (req_ready[0]) begin
          nfail++;
          $display("FAIL backpressure: req_ready[0] 1, required 0");
        end
      end
      chk(0);
      chk(1);
      pv = resp_valid;
      ph = resp_valid & resp_ready;
    end
  end

  initial begin
    int w;
    vec_t z;
    v0[0] = '{3'b000, 1'b0, 5'd4,  32'h0,        32'h000000F1, 4'h3, 32'h00000F10};
    v0[1] = '{3'b001, 1'b0, 5'd8,  32'h0,        32'h12345678, 4'h5, 32'h34567800};
    v0[2] = '{3'b100, 1'b0, 5'd1,  32'h0,        32'h80000001, 4'h6, 32'h00000002};
    v0[3] = '{3'b011, 1'b0, 5'd0,  32'h0,        32'h80000000, 4'h7, 32'h80000000};
    v1[0] = '{3'b011, 1'b1, 5'd2,  32'hFFFFFFE8, 32'h80001234, 4'h9, 32'hFF800012};
    v1[1] = '{3'b010, 1'b1, 5'd2,  32'hFFFFFFE8, 32'h80001234, 4'hA, 32'h00800012};
    v1[2] = '{3'b011, 1'b1, 5'd3,  32'h0000001F, 32'h80000000, 4'hB, 32'hFFFFFFFF};
    v1[3] = '{3'b010, 1'b0, 5'd31, 32'h00000005, 32'h80000000, 4'hC, 32'h00000001};
    z     = '{3'b000, 1'b0, 5'd0,  32'h0,        32'h0,        4'h0, 32'h0};
    drive(0, z, 1'b0);
    drive(1, z, 1'b0);
    rdy0 = 1'b1;
    rdy1 = 1'b1;
    rst  = 1'b1;

    // Reset state, with requests pending
    repeat (3) @(negedge clk);
    vld0 = 1'b1;
    vld1 = 1'b1;
    #1;
    nchk += 4;
    if (req_ready !== 2'b00) begin
      nfail++; $display("FAIL rst_req_ready: got %b, required 00", req_ready);
    end
    if (resp_valid !== 2'b00) begin
      nfail++; $display("FAIL rst_resp_valid: got %b, required 00", resp_valid);
    end
    if (resp_data !== 64'h0) begin
      nfail++; $display("FAIL rst_resp_data: got %h, required 0", resp_data);
    end
    if (resp_tag !== 8'h0) begin
      nfail++; $display("FAIL rst_resp_tag: got %h, required 0", resp_tag);
    end
    vld0 = 1'b0;
    vld1 = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;

    // Single requests on each port
    send(0, v0[0], w);
    drain();
    send(1, v1[0], w);
    send(1, v1[1], w);
    drain();

    // Both ports streaming from reset: strict alternation
    do_reset();
    glog.delete();
    gcyc.delete();
    fork
      stream(0);
      stream(1);
    join
    drain();
    nchk++;
    if (glog.size() != 8) begin
      nfail++; $display("FAIL rr_count: %0d grants, required 8", glog.size());
    end
    for (int k = 0; k < glog.size() && k < 8; k++) begin
      nchk++;
      if (glog[k] != k % 2 || gcyc[k] != gcyc[0] + k) begin
        nfail++;
        $display("FAIL rr_order: grant %0d to port %0d at edge %0d, required port %0d at edge %0d",
                 k, glog[k], gcyc[k], k % 2, gcyc[0] + k);
      end
    end

    // Port 0 buffer held full; port 1 must still flow
    rdy0 = 1'b0;
    send(0, v0[0], w);
    drive(0, v0[1], 1'b1);
    hold0 = 1'b1;
    stream(1);
    hold0 = 1'b0;
    rdy0  = 1'b1;
    send(0, v0[1], w);
    nchk++;
    if (w != 0) begin
      nfail++; $display("FAIL resume: port 0 waited %0d cycles, required 0", w);
    end
    drain();

    // Reset with issue stage full and buffer 1 occupied
    rdy1 = 1'b0;
    send(1, v1[2], w);
    @(posedge clk);
    #1;
    send(0, v0[2], w);
    rst = 1'b1;
    #1;
    q0.delete();
    q1.delete();
    nchk += 2;
    if (resp_valid !== 2'b00) begin
      nfail++; $display("FAIL midrst_valid: got %b, required 00", resp_valid);
    end
    if (resp_data !== 64'h0) begin
      nfail++; $display("FAIL midrst_data: got %h, required 0", resp_data);
    end
    @(posedge clk);
    #1;
    rst  = 1'b0;
    rdy1 = 1'b1;
    glog.delete();
    fork
      send(0, v0[3], w);
      send(1, v1[3], w);
    join
    nchk++;
    if (glog.size() != 2 || glog[0] != 0 || glog[1] != 1) begin
      nfail++; $display("FAIL rr_after_rst: first grant order wrong, required port 0 then 1");
    end
    drain();

`ifdef SHIFT_ARB_STALLCNT_EN
    // Port 1 held off five cycles by pending entry and full buffer
    do_reset();
    rdy1 = 1'b0;
    send(1, v1[0], w);
    drive(1, v1[1], 1'b1);
    repeat (5) @(posedge clk);
    #1;
    vld1 = 1'b0;
    nchk += 2;
    if (sc1 !== 32'd5) begin
      nfail++; $display("FAIL stall_cnt1: got %0d, required 5", sc1);
    end
    if (sc0 !== 32'd0) begin
      nfail++; $display("FAIL stall_cnt0: got %0d, required 0", sc0);
    end
    rdy1 = 1'b1;
    drain();
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", nchk, nfail);
    $finish;
  end

endmodule
